// File: rtl/lms_predict_ctrl_pkg.sv
// rtl/lms_predict_ctrl_pkg.sv - shared constants for the LMS prediction controller
package lms_predict_ctrl_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ISSUE    = 3'd1;
    localparam logic [2:0] ST_WAIT_MUL = 3'd2;
    localparam logic [2:0] ST_ACCUM    = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    localparam int LMS_SHIFT   = 13;
    localparam int DEF_TAPS    = 4;
    localparam int DEF_TIMEOUT = 63;
    localparam int ACC_W       = 34;
    localparam int SAMPLE_W    = 16;
    localparam int PROD_W      = 32;

    // Products are summed in a wider signed accumulator so four full-scale taps cannot overflow.
    function automatic logic signed [ACC_W-1:0] sext_prod(input logic [PROD_W-1:0] p);
        return {{(ACC_W - PROD_W){p[PROD_W-1]}}, p};
    endfunction

endpackage

// File: rtl/lms_predict_ctrl_if.sv
// rtl/lms_predict_ctrl_if.sv - request/result and shared-multiplier signals of the controller
interface lms_predict_ctrl_if
    import lms_predict_ctrl_pkg::*;
#(
    parameter int TAPS = DEF_TAPS
);
    logic                       req;
    logic [SAMPLE_W*TAPS-1:0]   history;
    logic [SAMPLE_W*TAPS-1:0]   weights;
    logic                       busy;
    logic                       done;
    logic [31:0]                prediction;
    logic                       error;
    logic                       mul_start;
    logic [SAMPLE_W-1:0]        mul_a;
    logic [SAMPLE_W-1:0]        mul_b;
    logic [PROD_W-1:0]          mul_result;
    logic                       mul_finished;

    modport master (
        output req, history, weights, mul_result, mul_finished,
        input  busy, done, prediction, error, mul_start, mul_a, mul_b
    );

    modport slave (
        input  req, history, weights, mul_result, mul_finished,
        output busy, done, prediction, error, mul_start, mul_a, mul_b
    );
endinterface

// File: rtl/lms_predict_ctrl.sv
// rtl/lms_predict_ctrl.sv - sequences one LMS dot product through an external shared multiplier
module lms_predict_ctrl
    import lms_predict_ctrl_pkg::*;
#(
    parameter int TAPS    = DEF_TAPS,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    lms_predict_ctrl_if.slave bus
);
    localparam int IDX_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam int VEC_W = SAMPLE_W * TAPS;

    logic [2:0]              state_q, state_d;
    logic [VEC_W-1:0]        hist_q, hist_d;
    logic [VEC_W-1:0]        wts_q, wts_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [WD_W-1:0]         wd_q, wd_d;
    logic [PROD_W-1:0]       prod_q, prod_d;
    logic [31:0]             pred_q, pred_d;
    logic                    err_q, err_d;

    logic signed [ACC_W-1:0] acc_sum;
    logic [SAMPLE_W-1:0]     hist_tap, wts_tap;
    logic                    op_live;

    assign acc_sum  = acc_q + sext_prod(prod_q);
    assign hist_tap = hist_q[{idx_q, 4'b0000} +: SAMPLE_W];
    assign wts_tap  = wts_q[{idx_q, 4'b0000} +: SAMPLE_W];

    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        wts_d   = wts_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        wd_d    = wd_q;
        prod_d  = prod_q;
        pred_d  = pred_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    hist_d  = bus.history;
                    wts_d   = bus.weights;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wd_d    = '0;
                state_d = ST_WAIT_MUL;
            end
            ST_WAIT_MUL: begin
                if (bus.mul_finished) begin
                    prod_d  = bus.mul_result;
                    state_d = ST_ACCUM;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    pred_d  = '0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_ACCUM: begin
                acc_d = acc_sum;
                if (idx_q == IDX_W'(TAPS - 1)) begin
                    // Result is registered on entry to DONE so it is already valid while done is high.
                    pred_d  = 32'(acc_sum >>> LMS_SHIFT);
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
            hist_q  <= '0;
            wts_q   <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            wd_q    <= '0;
            prod_q  <= '0;
            pred_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            wts_q   <= wts_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            wd_q    <= wd_d;
            prod_q  <= prod_d;
            pred_q  <= pred_d;
            err_q   <= err_d;
        end
    end

    // Operands are held from ISSUE through WAIT_MUL because the multiplier re-reads them at completion.
    assign op_live        = (state_q == ST_ISSUE) || (state_q == ST_WAIT_MUL);
    assign bus.mul_a      = op_live ? hist_tap : '0;
    assign bus.mul_b      = op_live ? wts_tap : '0;
    assign bus.mul_start  = (state_q == ST_ISSUE);
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.done       = (state_q == ST_DONE);
    assign bus.prediction = pred_q;
    assign bus.error      = err_q;

endmodule

// File: tb/tb_lms_predict_ctrl.sv
// tb/tb_lms_predict_ctrl.sv - self-checking bench for lms_predict_ctrl
module tb_lms_predict_ctrl;
    localparam int TAPS    = 4;
    localparam int TIMEOUT = 63;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lms_predict_ctrl_if #(.TAPS(TAPS)) bus();

    lms_predict_ctrl #(.TAPS(TAPS), .TIMEOUT(TIMEOUT)) dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural shared multiplier; the bench only writes the knobs, the model owns its own state.
    int  mode           = 0;
    int  fixed_lat      = 18;
    bit  stray_accum    = 1'b0;
    int  idle_stray_cnt = 0;

    int  cnt = 0, lat_total = 0, op_total = 0, op_err = 0, idle_seen = 0;
    bit  stray_pending = 1'b0;
    logic [15:0] cap_a, cap_b;

    always @(negedge clk) begin
        logic signed [31:0] prod;
        int lat;
        if (rst) begin
            cnt               = 0;
            stray_pending     = 1'b0;
            bus.mul_finished  = 1'b0;
            bus.mul_result    = '0;
        end else begin
            if (bus.mul_finished) begin
                bus.mul_finished = 1'b0;
                if (stray_pending) begin
                    stray_pending    = 1'b0;
                    bus.mul_finished = 1'b1;
                    bus.mul_result   = 32'h5a5a_1234;
                end
            end else if (idle_seen != idle_stray_cnt) begin
                idle_seen        = idle_stray_cnt;
                bus.mul_finished = 1'b1;
                bus.mul_result   = 32'h7fff_ffff;
            end
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    if ({bus.mul_a, bus.mul_b} !== {cap_a, cap_b}) op_err++;
                    prod             = $signed(cap_a) * $signed(cap_b);
                    bus.mul_result   = prod;
                    bus.mul_finished = 1'b1;
                    stray_pending    = stray_accum;
                end
            end
            if (bus.mul_start && mode == 0) begin
                lat       = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 20));
                cnt       = lat;
                cap_a     = bus.mul_a;
                cap_b     = bus.mul_b;
                lat_total += lat;
                op_total++;
            end
        end
    end

    function automatic logic [63:0] pk(input int a0, input int a1, input int a2, input int a3);
        return {a3[15:0], a2[15:0], a1[15:0], a0[15:0]};
    endfunction

    // Reference: exact integer dot product, then floor division by 2^13.
    function automatic logic signed [31:0] ref_pred(input logic [63:0] h, input logic [63:0] w);
        longint s = 0;
        longint q;
        for (int i = 0; i < TAPS; i++)
            s += longint'($signed(h[16*i +: 16])) * longint'($signed(w[16*i +: 16]));
        q = s / 8192;
        if ((s % 8192) != 0 && s < 0) q -= 1;
        return 32'(q);
    endfunction

    task automatic run_op(input string tag, input logic [63:0] h, input logic [63:0] w,
                          input logic signed [31:0] exp_pred, input bit exp_err,
                          input int exp_starts, input bit timeout_path, input bit inject);
        int k, starts, lat0, ops0, oe0, exp_lat;
        bit seen;
        logic signed [31:0] got_p;
        logic got_e;
        @(negedge clk);
        lat0 = lat_total; ops0 = op_total; oe0 = op_err;
        bus.history = h; bus.weights = w; bus.req = 1'b1;
        k = 0; starts = 0; seen = 1'b0; got_p = '0; got_e = 1'b0;
        while (!seen && k < 3000) begin
            @(negedge clk);
            k++;
            if (k == 1) bus.req = 1'b0;
            if (inject && k == 5) begin
                bus.req = 1'b1; bus.history = ~h; bus.weights = ~w;
            end
            if (inject && k == 7) bus.req = 1'b0;
            if (bus.mul_start) starts++;
            if (bus.done) begin
                seen = 1'b1; got_p = bus.prediction; got_e = bus.error;
            end
        end
        exp_lat = timeout_path ? TIMEOUT + 2 : (lat_total - lat0) + 2 * (op_total - ops0) + 1;
        chk({tag, "_done_seen"}, seen, 1);
        chk({tag, "_prediction"}, got_p, exp_pred);
        chk({tag, "_error"}, got_e, exp_err);
        chk({tag, "_mul_starts"}, starts, exp_starts);
        chk({tag, "_latency"}, k, exp_lat);
        chk({tag, "_operand_hold"}, op_err - oe0, 0);
        @(negedge clk);
        chk({tag, "_done_single"}, bus.done, 0);
        chk({tag, "_idle_after"}, bus.busy, 0);
        chk({tag, "_pred_held"}, $signed(bus.prediction), exp_pred);
    endtask

    typedef struct {
        string              name;
        logic [63:0]        h;
        logic [63:0]        w;
        logic signed [31:0] pred;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int k;
        logic [63:0] rh, rw;

        vecs[0] = '{"basic",    pk(0, 0, 100, 200),             pk(0, 0, -8192, 16384),         32'sd300};
        vecs[1] = '{"floor_m1", pk(0, 0, 0, -1),                pk(0, 0, 0, 1),                 -32'sd1};
        vecs[2] = '{"negmax2",  pk(-32768, -32768, -32768, -32768), pk(-32768, -32768, -32768, -32768), 32'sd524288};
        vecs[3] = '{"negmax_p", pk(-32768, -32768, -32768, -32768), pk(32767, 32767, 32767, 32767), -32'sd524272};
        vecs[4] = '{"unity",    pk(1, 2, 3, 4),                 pk(8192, 8192, 8192, 8192),     32'sd10};
        vecs[5] = '{"mixed",    pk(-3, 5, 0, 0),                pk(4096, -4096, 0, 0),          -32'sd4};
        vecs[6] = '{"floor_m2", pk(1, 0, 0, 0),                 pk(-8193, 0, 0, 0),             -32'sd2};

        bus.req = 1'b0; bus.history = '0; bus.weights = '0;
        rst = 1'b0;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_prediction", bus.prediction, 0);
        chk("reset_error", bus.error, 0);
        chk("reset_mul_start", bus.mul_start, 0);
        chk("reset_mul_ab", {bus.mul_a, bus.mul_b}, 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++)
            run_op(vecs[i].name, vecs[i].h, vecs[i].w, vecs[i].pred, 1'b0, TAPS, 1'b0, 1'b0);

        // Stray product-valid while idle must not start anything.
        @(negedge clk);
        #2 idle_stray_cnt++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_stray_busy", bus.busy, 0);
        end
        run_op("after_idle_stray", vecs[0].h, vecs[0].w, vecs[0].pred, 1'b0, TAPS, 1'b0, 1'b0);

        stray_accum = 1'b1;
        run_op("accum_stray", vecs[4].h, vecs[4].w, vecs[4].pred, 1'b0, TAPS, 1'b0, 1'b0);
        stray_accum = 1'b0;

        run_op("req_while_busy", vecs[0].h, vecs[0].w, vecs[0].pred, 1'b0, TAPS, 1'b0, 1'b1);

        fixed_lat = 0;
        for (int i = 0; i < 10; i++) begin
            rh = {$urandom, $urandom};
            rw = {$urandom, $urandom};
            if (i == 0) rh[15:0] = 16'h8000;
            run_op("random", rh, rw, ref_pred(rh, rw), 1'b0, TAPS, 1'b0, 1'b0);
        end
        fixed_lat = 18;

        mode = 1;
        run_op("timeout", vecs[4].h, vecs[4].w, 32'sd0, 1'b1, 1, 1'b1, 1'b0);
        mode = 0;

        run_op("pre_reset", vecs[0].h, vecs[0].w, vecs[0].pred, 1'b0, TAPS, 1'b0, 1'b0);

        // Reset while the third tap's multiply is outstanding.
        @(negedge clk);
        bus.history = vecs[2].h; bus.weights = vecs[2].w; bus.req = 1'b1;
        k = 0;
        begin
            int starts = 0;
            while (starts < 3 && k < 500) begin
                @(negedge clk);
                k++;
                bus.req = 1'b0;
                if (bus.mul_start) starts++;
            end
            chk("midreset_reached_tap2", starts, 3);
        end
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midreset_busy", bus.busy, 0);
        chk("midreset_done", bus.done, 0);
        chk("midreset_prediction", bus.prediction, 0);
        chk("midreset_error", bus.error, 0);
        chk("midreset_mul_start", bus.mul_start, 0);
        chk("midreset_mul_ab", {bus.mul_a, bus.mul_b}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_op("post_reset", vecs[3].h, vecs[3].w, vecs[3].pred, 1'b0, TAPS, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete, got %0d checks expected completion", n_chk);
        $fatal(1, "bench time limit exceeded");
    end

endmodule
